// File: rtl/gc_controller_poll.sv
// gc_controller_poll
//   Polls one GameCube controller over its single-wire open-drain bus and
//   publishes the latest 64-bit button/stick status (one instance per player).
//
//   Ports:
//     clock         in   system clock
//     reset         in   asynchronous, active-high reset
//     data_in       in   raw bus level from the gpio pin (asynchronous)
//     data_oe       out  1 = pull bus low, 0 = release (open-drain enable)
//     rumble        in   rumble bit sent in the poll command
//     status [63:0] out  last good response, MSB = first bit received
//     status_valid  out  one-cycle pulse when status updates
//     timeout_err   out  set when a poll fails, cleared by the next good poll
//     busy          out  high while a transaction is in progress
//
//   Optional feature macro: GC_ORIGIN_CAL_EN
//     When defined, the first transaction after reset is an origin probe
//     (0x41, 80-bit response); stick bytes of later polls are re-centred
//     against the stored origin and clamped to 0..255.
//
//   Parameters: US_CYCLES (clocks per us), POLL_CYCLES (poll period),
//   RESP_TO_US (first-response timeout), BIT_TO_US (inter-edge timeout).
module gc_controller_poll #(
    parameter int unsigned US_CYCLES   = 50,
    parameter int unsigned POLL_CYCLES = 833333,
    parameter int unsigned RESP_TO_US  = 200,
    parameter int unsigned BIT_TO_US   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_in,
    output logic        data_oe,
    input  logic        rumble,
    output logic [63:0] status,
    output logic        status_valid,
    output logic        timeout_err,
    output logic        busy
);

    localparam int unsigned PRE_W  = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;
    localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
`ifdef GC_ORIGIN_CAL_EN
    localparam int unsigned SR_W = 80;
`else
    localparam int unsigned SR_W = 64;
`endif

    localparam logic [7:0] RESP_LIM = 8'(RESP_TO_US - 1);
    localparam logic [7:0] BIT_LIM  = 8'(BIT_TO_US - 1);

    typedef enum logic [3:0] {
        IDLE, TX_LOW, TX_HIGH, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP, DONE, ERR
    } state_t;

    state_t            state, state_next;
    logic              sync1, sync2, sync3;
    logic              fall, rise;
    logic [PRE_W-1:0]  presc;
    logic              tick;
    logic [7:0]        us_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_wrap;
    logic [23:0]       cmd_sr;
    logic [4:0]        tx_cnt;
    logic [4:0]        tx_last;
    logic [6:0]        rx_cnt;
    logic [6:0]        rx_last;
    logic [SR_W-1:0]   rx_sr;
    logic              stop_fell;
    logic              timer_clr, tx_shift, rx_shift, oe_next;
    logic              start_tx;

`ifdef GC_ORIGIN_CAL_EN
    logic        cal_done;
    logic        probe;
    logic [31:0] origin;

    assign probe   = ~cal_done;
    assign tx_last = probe ? 5'd7 : 5'd23;
    assign rx_last = probe ? 7'd79 : 7'd63;

    // raw - origin + 128, clamped to an unsigned byte
    function automatic logic [7:0] center(input logic [7:0] raw, input logic [7:0] org);
        logic signed [9:0] v;
        v = $signed({2'b00, raw}) - $signed({2'b00, org}) + 10'sd128;
        if (v < 10'sd0)
            return 8'h00;
        else if (v > 10'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction
`else
    assign tx_last = 5'd23;
    assign rx_last = 7'd63;
`endif

    assign fall      = sync3 & ~sync2;
    assign rise      = ~sync3 & sync2;
    assign tick      = (presc == PRE_W'(US_CYCLES - 1));
    assign poll_wrap = (poll_cnt == POLL_W'(POLL_CYCLES - 1));
    assign start_tx  = (state == IDLE) && poll_wrap;

    // Next state and strobes
    always_comb begin
        state_next = state;
        timer_clr  = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        case (state)
            IDLE:      if (poll_wrap) state_next = TX_LOW;
            // '0' is 3 us low / 1 us high, '1' is 1 us low / 3 us high
            TX_LOW:    if (tick && us_cnt == (cmd_sr[23] ? 8'd0 : 8'd2)) state_next = TX_HIGH;
            TX_HIGH:   if (tick && us_cnt == (cmd_sr[23] ? 8'd2 : 8'd0)) begin
                           tx_shift   = 1'b1;
                           state_next = (tx_cnt == tx_last) ? TX_STOP : TX_LOW;
                       end
            TX_STOP:   if (tick) state_next = RX_WAIT;
            RX_WAIT:   if (fall)
                           state_next = RX_SAMPLE;
                       else if (tick && us_cnt == ((rx_cnt == 7'd0) ? RESP_LIM : BIT_LIM))
                           state_next = ERR;
            RX_SAMPLE: if (tick && us_cnt == 8'd1) begin
                           rx_shift   = 1'b1;
                           state_next = (rx_cnt == rx_last) ? RX_STOP : RX_WAIT;
                       end
            RX_STOP:   if (stop_fell && rise)
                           state_next = DONE;
                       else if (fall)
                           timer_clr = 1'b1;
                       else if (tick && us_cnt == BIT_LIM)
                           state_next = ERR;
            DONE:      state_next = IDLE;
            ERR:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // Leaving RX_SAMPLE keeps the timer running so the inter-bit timeout
        // is measured from the falling edge, not from the sample point.
        if (state_next != state && state != RX_SAMPLE)
            timer_clr = 1'b1;
        oe_next = (state_next == TX_LOW) || (state_next == TX_STOP);
    end

    // State register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data_oe <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            data_oe <= oe_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Synchronizer, poll timer, microsecond timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            poll_cnt <= '0;
            presc    <= '0;
            us_cnt   <= '0;
        end else begin
            sync1    <= data_in;
            sync2    <= sync1;
            sync3    <= sync2;
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            if (timer_clr) begin
                presc  <= '0;
                us_cnt <= '0;
            end else if (tick) begin
                presc <= '0;
                if (us_cnt != 8'hFF)
                    us_cnt <= us_cnt + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Command/response datapath and status publication
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_sr       <= '0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            rx_sr        <= '0;
            stop_fell    <= 1'b0;
            status       <= '0;
            status_valid <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef GC_ORIGIN_CAL_EN
            cal_done     <= 1'b0;
            origin       <= '0;
`endif
        end else begin
            status_valid <= 1'b0;
            if (start_tx) begin
                // Poll command bytes 0x40 0x03 0x00, rumble in bit 0 of the last byte
`ifdef GC_ORIGIN_CAL_EN
                cmd_sr <= probe ? {8'h41, 16'h0000} : {8'h40, 8'h03, 7'b0000000, rumble};
`else
                cmd_sr <= {8'h40, 8'h03, 7'b0000000, rumble};
`endif
                tx_cnt    <= '0;
                rx_cnt    <= '0;
                stop_fell <= 1'b0;
            end
            if (tx_shift) begin
                cmd_sr <= {cmd_sr[22:0], 1'b0};
                tx_cnt <= tx_cnt + 5'd1;
            end
            if (rx_shift) begin
                rx_sr  <= {rx_sr[SR_W-2:0], sync2};
                rx_cnt <= rx_cnt + 7'd1;
            end
            if (state == RX_STOP && fall)
                stop_fell <= 1'b1;
            if (state == DONE) begin
`ifdef GC_ORIGIN_CAL_EN
                if (probe) begin
                    origin   <= rx_sr[63:32];
                    cal_done <= 1'b1;
                end else begin
                    status <= {rx_sr[63:48],
                               center(rx_sr[47:40], origin[31:24]),
                               center(rx_sr[39:32], origin[23:16]),
                               center(rx_sr[31:24], origin[15:8]),
                               center(rx_sr[23:16], origin[7:0]),
                               rx_sr[15:0]};
                    status_valid <= 1'b1;
                end
`else
                status       <= rx_sr;
                status_valid <= 1'b1;
`endif
                timeout_err <= 1'b0;
            end
            if (state == ERR)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gc_controller_poll.sv
// tb_gc_controller_poll
//   Self-checking bench for gc_controller_poll (default build, origin
//   calibration macro GC_ORIGIN_CAL_EN undefined). A behavioural controller
//   model sits on the open-drain bus, decodes the command from pulse widths
//   and answers with randomized 64-bit responses.
module tb_gc_controller_poll;

    localparam int US      = 10;
    localparam int POLL    = 4500;
    localparam int RESP_TO = 200;
    localparam int BIT_TO  = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        data_oe;
    logic        rumble;
    logic        status_valid;
    logic        timeout_err;
    logic        busy;
    logic        dev_low;
    logic        data_in;
    logic [63:0] status;

    // Open-drain bus with pull-up: low if either side pulls
    assign data_in = ~(data_oe | dev_low);

    always #5 clock = ~clock;

    gc_controller_poll #(
        .US_CYCLES  (US),
        .POLL_CYCLES(POLL),
        .RESP_TO_US (RESP_TO),
        .BIT_TO_US  (BIT_TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .data_oe     (data_oe),
        .rumble      (rumble),
        .status      (status),
        .status_valid(status_valid),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_status;
    logic [23:0] cap_cmd;
    int          cap_low [25];
    int          cap_valid;
    logic        cap_busy;

    function automatic logic [23:0] poll_cmd(input logic r);
        return 24'h400300 | {23'd0, r};
    endfunction

    task automatic wait_tx_start(output bit ok);
        int k;
        k = 0;
        while (!data_oe && k < 2 * POLL) begin
            @(negedge clock);
            k++;
        end
        ok = data_oe;
    endtask

    // Starts at a negedge where data_oe is already high; records the width
    // of each of the 25 low pulses and decodes the 24 command bits.
    task automatic capture_tx(output bit ok);
        ok       = 1'b1;
        cap_cmd  = '0;
        cap_busy = busy;
        for (int i = 0; i < 25; i++) begin
            int w;
            w = 0;
            while (data_oe && w < 8 * US) begin
                @(negedge clock);
                w++;
            end
            cap_low[i] = w;
            if (i < 24) begin
                cap_cmd = {cap_cmd[22:0], (w < 2 * US)};
                w = 0;
                while (!data_oe && w < 8 * US) begin
                    @(negedge clock);
                    w++;
                end
                if (!data_oe) ok = 1'b0;
            end
        end
        if (data_oe) ok = 1'b0;
    endtask

    task automatic respond(input logic [63:0] resp, input int nbits, input int delay_us);
        repeat (delay_us * US) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = resp[63 - i];
            dev_low = 1'b1;
            repeat ((b ? 1 : 3) * US) @(negedge clock);
            dev_low = 1'b0;
            repeat ((b ? 3 : 1) * US) @(negedge clock);
        end
        if (nbits == 64) begin
            dev_low = 1'b1;
            repeat (US) @(negedge clock);
            dev_low = 1'b0;
        end
    endtask

    task automatic finish_poll(output bit ok);
        int k;
        k = 0;
        cap_valid = 0;
        while (busy && k < (RESP_TO + 20) * US) begin
            if (status_valid) cap_valid++;
            @(negedge clock);
            k++;
        end
        ok = !busy;
        repeat (5) begin
            if (status_valid) cap_valid++;
            @(negedge clock);
        end
    endtask

    task automatic run_poll(input logic [63:0] resp, input int nbits, output bit ok);
        bit a, b, c;
        wait_tx_start(a);
        capture_tx(b);
        respond(resp, nbits, int'($urandom_range(1, 5)));
        finish_poll(c);
        ok = a && b && c;
    endtask

    task automatic test_reset();
        n_cmp++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        n_cmp++; if (status !== 64'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", status); end
        n_cmp++; if (status_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", status_valid); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        n_cmp++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL idle_data_oe: got %b want 0", data_oe); end
        exp_status = 64'd0;
    endtask

    task automatic test_good_poll();
        logic [63:0] resp;
        bit ok;
        resp   = 64'h0080_8080_8080_1F1F;
        rumble = 1'b0;
        run_poll(resp, 64, ok);
        exp_status = resp;
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL good_complete: got %b want 1", ok); end
        n_cmp++; if (cap_busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_tx: got %b want 1", cap_busy); end
        n_cmp++; if (cap_cmd !== poll_cmd(1'b0)) begin n_fail++; $display("FAIL good_cmd: got %h want %h", cap_cmd, poll_cmd(1'b0)); end
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL good_status: got %h want %h", status, exp_status); end
        n_cmp++; if (cap_valid != 1) begin n_fail++; $display("FAIL good_valid_pulses: got %0d want 1", cap_valid); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_rumble_tx();
        logic [63:0] resp;
        logic [23:0] cmd;
        bit ok;
        resp   = {$urandom, $urandom};
        rumble = 1'b1;
        cmd    = poll_cmd(1'b1);
        run_poll(resp, 64, ok);
        exp_status = resp;
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rumble_complete: got %b want 1", ok); end
        n_cmp++; if (cap_cmd !== 24'h400301) begin n_fail++; $display("FAIL rumble_cmd: got %h want 400301", cap_cmd); end
        for (int i = 0; i < 24; i++) begin
            int want;
            want = cmd[23 - i] ? US : 3 * US;
            n_cmp++;
            if (cap_low[i] != want) begin
                n_fail++;
                $display("FAIL rumble_low_width[%0d]: got %0d want %0d", i, cap_low[i], want);
            end
        end
        n_cmp++; if (cap_low[24] != US) begin n_fail++; $display("FAIL stop_low_width: got %0d want %0d", cap_low[24], US); end
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL rumble_status: got %h want %h", status, exp_status); end
        n_cmp++; if (cap_valid != 1) begin n_fail++; $display("FAIL rumble_valid_pulses: got %0d want 1", cap_valid); end
    endtask

    task automatic test_no_response();
        bit a, b;
        int k, vcnt, lo, hi;
        rumble = 1'(($urandom & 1));
        wait_tx_start(a);
        capture_tx(b);
        k    = cap_low[24];
        vcnt = 0;
        while (!timeout_err && k < (RESP_TO + 10) * US) begin
            if (status_valid) vcnt++;
            @(negedge clock);
            k++;
        end
        lo = (RESP_TO + 1) * US;
        hi = lo + 3;
        n_cmp++; if (!(a && b)) begin n_fail++; $display("FAIL noresp_tx: got %b%b want 11", a, b); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL noresp_err: got %b want 1", timeout_err); end
        n_cmp++; if (k < lo || k > hi) begin n_fail++; $display("FAIL noresp_latency: got %0d want %0d..%0d", k, lo, hi); end
        repeat (5) @(negedge clock);
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL noresp_status: got %h want %h", status, exp_status); end
        n_cmp++; if (vcnt != 0) begin n_fail++; $display("FAIL noresp_valid: got %0d want 0", vcnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noresp_busy: got %b want 0", busy); end
    endtask

    task automatic test_truncated();
        bit ok;
        rumble = 1'(($urandom & 1));
        run_poll({$urandom, $urandom}, 30, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL trunc_complete: got %b want 1", ok); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL trunc_err: got %b want 1", timeout_err); end
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL trunc_status: got %h want %h", status, exp_status); end
        n_cmp++; if (cap_valid != 0) begin n_fail++; $display("FAIL trunc_valid: got %0d want 0", cap_valid); end
    endtask

    task automatic test_random_polls();
        for (int n = 0; n < 3; n++) begin
            logic [63:0] resp;
            bit ok;
            rumble = 1'(($urandom & 1));
            resp   = {$urandom, $urandom};
            run_poll(resp, 64, ok);
            exp_status = resp;
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_complete[%0d]: got %b want 1", n, ok); end
            n_cmp++; if (cap_cmd !== poll_cmd(rumble)) begin n_fail++; $display("FAIL rand_cmd[%0d]: got %h want %h", n, cap_cmd, poll_cmd(rumble)); end
            n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL rand_status[%0d]: got %h want %h", n, status, exp_status); end
            n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rand_err_cleared[%0d]: got %b want 0", n, timeout_err); end
            n_cmp++; if (cap_valid != 1) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0d want 1", n, cap_valid); end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [63:0] resp;
        bit a, b, c;
        int k;
        wait_tx_start(a);
        repeat ($urandom_range(2, 20)) @(negedge clock);
        reset = 1'b1;
        #1;
        exp_status = 64'd0;
        n_cmp++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL midtx_data_oe: got %b want 0", data_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midtx_busy: got %b want 0", busy); end
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL midtx_status: got %h want 0", status); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        k = 0;
        while (!data_oe && k < 2 * POLL) begin
            @(negedge clock);
            k++;
        end
        n_cmp++; if (k < POLL - 1 || k > POLL + 1) begin n_fail++; $display("FAIL midtx_first_poll: got %0d want %0d", k, POLL); end
        resp   = {$urandom, $urandom};
        rumble = 1'b0;
        capture_tx(b);
        respond(resp, 64, 2);
        finish_poll(c);
        exp_status = resp;
        n_cmp++; if (!(a && b && c)) begin n_fail++; $display("FAIL midtx_complete: got %b%b%b want 111", a, b, c); end
        n_cmp++; if (status !== exp_status) begin n_fail++; $display("FAIL midtx_after_status: got %h want %h", status, exp_status); end
    endtask

    initial begin
        reset   = 1'b1;
        dev_low = 1'b0;
        rumble  = 1'b0;
        repeat (5) @(negedge clock);
        test_reset();
        test_good_poll();
        test_rumble_tx();
        test_no_response();
        test_truncated();
        test_random_polls();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
